// File: rtl/rtos_pkg.sv
// rtos_pkg: shared definitions for the RTOS dispatcher slice.
//   - default widths for task ids, priorities, TCB pointers and the tick counter
//   - default time-slice length
//   - dispatcher FSM state encoding
//   - null TCB constant, reported as the outgoing TCB when no task is running
package rtos_pkg;

  localparam int DEF_ID_W        = 8;
  localparam int DEF_PRI_W       = 6;
  localparam int DEF_TCB_W       = 32;
  localparam int DEF_TICK_W      = 32;
  localparam int DEF_SLICE_TICKS = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ROTATE  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_FETCH   = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_REQ     = 3'd5
  } state_t;

  localparam logic [DEF_TCB_W-1:0] NULL_TCB = '0;

endpackage

// File: rtl/rtos_tick_slice.sv
// rtos_tick_slice: system tick counter and time-slice down-counter.
// Ports:
//   aclk           in   clock
//   areset         in   synchronous active-high reset
//   tick_in        in   one-cycle system tick pulse
//   dec_en         in   slice may count down on this cycle's tick
//   reload         in   reload slice to SLICE_TICKS (wins over a decrement)
//   tickval_out    out  free-running tick count, wraps to 0
//   slice_zero_out out  slice has expired
module rtos_tick_slice
  import rtos_pkg::*;
#(
  parameter int TICK_W      = DEF_TICK_W,
  parameter int SLICE_TICKS = DEF_SLICE_TICKS
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              tick_in,
  input  logic              dec_en,
  input  logic              reload,
  output logic [TICK_W-1:0] tickval_out,
  output logic              slice_zero_out
);

  localparam int SL_W = $clog2(SLICE_TICKS + 1);
  localparam logic [SL_W-1:0] SLICE_INIT = SL_W'(SLICE_TICKS);

  logic [TICK_W-1:0] r_tick;
  logic [SL_W-1:0]   r_slice;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_tick  <= '0;
      r_slice <= SLICE_INIT;
    end else begin
      if (tick_in) begin
        r_tick <= r_tick + 1'b1;
      end
      // Slice saturates at zero; the dispatcher decides when to reload it.
      if (reload) begin
        r_slice <= SLICE_INIT;
      end else if (tick_in && dec_en && (r_slice != '0)) begin
        r_slice <= r_slice - 1'b1;
      end
    end
  end

  assign tickval_out    = r_tick;
  assign slice_zero_out = (r_slice == '0);

endmodule

// File: rtl/rtos_dispatcher.sv
// rtos_dispatcher: decides when to preempt, time-slice or yield, fetches the
// incoming task's TCB through the list manager read port and performs a
// request/acknowledge context-switch handshake with the CPU.
// Ports:
//   aclk, areset             clock, synchronous active-high reset
//   sched_en                 kernel started; no new dispatch while low
//   tick_in, yield_in        one-cycle tick / software yield pulses
//   highpriority_in          highest ready priority from the list manager
//   ptr_hpritask_in          head task id at that priority
//   tcb_read_in              TCB read data, one cycle after addr_read_out
//   addr_read_out            TCB read address
//   tickval_out              system tick count
//   rotate_cmd/id/pri_out    one-cycle request to move current task to list tail
//   cs_req_out, cs_ack_in    context-switch handshake
//   cs_first_out             no outgoing task
//   cs_prev/next_tcb_out     outgoing / incoming TCB
//   cur_valid/id/pri_out     running task
module rtos_dispatcher
  import rtos_pkg::*;
#(
  parameter int ID_W        = DEF_ID_W,
  parameter int PRI_W       = DEF_PRI_W,
  parameter int TCB_W       = DEF_TCB_W,
  parameter int TICK_W      = DEF_TICK_W,
  parameter int SLICE_TICKS = DEF_SLICE_TICKS
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              sched_en,
  input  logic              tick_in,
  input  logic              yield_in,
  input  logic [PRI_W-1:0]  highpriority_in,
  input  logic [ID_W-1:0]   ptr_hpritask_in,
  input  logic [TCB_W-1:0]  tcb_read_in,
  output logic [ID_W-1:0]   addr_read_out,
  output logic [TICK_W-1:0] tickval_out,
  output logic              rotate_cmd_out,
  output logic [ID_W-1:0]   rotate_id_out,
  output logic [PRI_W-1:0]  rotate_pri_out,
  output logic              cs_req_out,
  input  logic              cs_ack_in,
  output logic              cs_first_out,
  output logic [TCB_W-1:0]  cs_prev_tcb_out,
  output logic [TCB_W-1:0]  cs_next_tcb_out,
  output logic              cur_valid_out,
  output logic [ID_W-1:0]   cur_id_out,
  output logic [PRI_W-1:0]  cur_pri_out
);

  state_t             r_state;
  state_t             w_state_next;
  logic               r_settle;
  logic               r_yield;
  logic               r_cur_valid;
  logic [ID_W-1:0]    r_cur_id;
  logic [PRI_W-1:0]   r_cur_pri;
  logic [TCB_W-1:0]   r_cur_tcb;
  logic [ID_W-1:0]    r_cand_id;
  logic [PRI_W-1:0]   r_cand_pri;
  logic [TCB_W-1:0]   r_next_tcb;

  logic               w_slice_reload;
  logic               w_yield_clr;
  logic               w_slice_zero;
  logic               w_dec_en;
  logic               w_switch;

  assign w_dec_en = (r_state == ST_IDLE) && r_cur_valid;
  assign w_switch = (r_state == ST_REQ) && cs_ack_in;

  rtos_tick_slice #(
    .TICK_W      (TICK_W),
    .SLICE_TICKS (SLICE_TICKS)
  ) u_tick_slice (
    .aclk           (aclk),
    .areset         (areset),
    .tick_in        (tick_in),
    .dec_en         (w_dec_en),
    .reload         (w_slice_reload),
    .tickval_out    (tickval_out),
    .slice_zero_out (w_slice_zero)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_slice_reload = 1'b0;
    w_yield_clr    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sched_en) begin
          if (!r_cur_valid) begin
            w_state_next = ST_FETCH;
          end else if (highpriority_in > r_cur_pri) begin
            w_state_next = ST_FETCH;
          end else if ((w_slice_zero || r_yield) && (highpriority_in == r_cur_pri)) begin
            w_state_next = ST_ROTATE;
          end else begin
            // Nothing to do: drop a stale yield and restart an expired slice.
            w_yield_clr    = 1'b1;
            w_slice_reload = w_slice_zero;
          end
        end
      end
      ST_ROTATE: begin
        w_state_next = ST_SETTLE;
        w_yield_clr  = 1'b1;
      end
      ST_SETTLE: begin
        // Second settle cycle: the list manager has applied the rotate.
        if (r_settle) begin
          if (ptr_hpritask_in == r_cur_id) begin
            w_slice_reload = 1'b1;
            w_state_next   = ST_IDLE;
          end else begin
            w_state_next = ST_FETCH;
          end
        end
      end
      ST_FETCH:   w_state_next = ST_CAPTURE;
      ST_CAPTURE: w_state_next = ST_REQ;
      ST_REQ: begin
        if (cs_ack_in) begin
          w_slice_reload = 1'b1;
          w_state_next   = ST_IDLE;
        end
      end
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_settle    <= 1'b0;
      r_yield     <= 1'b0;
      r_cur_valid <= 1'b0;
      r_cur_id    <= '0;
      r_cur_pri   <= '0;
      r_cur_tcb   <= '0;
      r_cand_id   <= '0;
      r_cand_pri  <= '0;
      r_next_tcb  <= '0;
    end else begin
      // A new yield wins over a clear in the same cycle so it is never lost.
      if (yield_in) begin
        r_yield <= 1'b1;
      end else if (w_yield_clr) begin
        r_yield <= 1'b0;
      end
      if (r_state == ST_ROTATE) begin
        r_settle <= 1'b0;
      end else if (r_state == ST_SETTLE) begin
        r_settle <= 1'b1;
      end
      // Candidate stays frozen until the handshake completes.
      if (r_state == ST_FETCH) begin
        r_cand_id  <= ptr_hpritask_in;
        r_cand_pri <= highpriority_in;
      end
      if (r_state == ST_CAPTURE) begin
        r_next_tcb <= tcb_read_in;
      end
      if (w_switch) begin
        r_cur_valid <= 1'b1;
        r_cur_id    <= r_cand_id;
        r_cur_pri   <= r_cand_pri;
        r_cur_tcb   <= r_next_tcb;
      end
    end
  end

  // The read address tracks the list head while fetching so the TCB arrives
  // in CAPTURE; afterwards it holds the latched candidate.
  assign addr_read_out   = (r_state == ST_FETCH) ? ptr_hpritask_in : r_cand_id;
  assign rotate_cmd_out  = (r_state == ST_ROTATE);
  assign rotate_id_out   = r_cur_id;
  assign rotate_pri_out  = r_cur_pri;
  assign cs_req_out      = (r_state == ST_REQ);
  assign cs_first_out    = (r_state == ST_REQ) && !r_cur_valid;
  assign cs_prev_tcb_out = r_cur_valid ? r_cur_tcb : TCB_W'(NULL_TCB);
  assign cs_next_tcb_out = r_next_tcb;
  assign cur_valid_out   = r_cur_valid;
  assign cur_id_out      = r_cur_id;
  assign cur_pri_out     = r_cur_pri;

endmodule

// File: doc/rtos_dispatcher.md
Name: rtos_dispatcher

Overview:
- Downstream consumer of lists_manager in the hardware RTOS.
- Watches highest-ready-priority and head-task outputs; decides when to preempt, time-slice or yield; fetches the incoming task's TCB through the list manager read port.
- Issues a context-switch request/acknowledge handshake to the CPU.
- Owns the system tick counter that feeds lists_manager tickval_in.

Parameters:
ID_W, 8, task id / list pointer width
PRI_W, 6, priority width; numerically larger = higher priority
TCB_W, 32, TCB pointer width
TICK_W, 32, tick counter width
SLICE_TICKS, 10, ticks per time slice among equal-priority tasks (>=1)

Ports:
aclk  in  1  clock, all logic rising edge
areset  in  1  synchronous, active-high reset
sched_en  in  1  kernel started; no dispatch while low
tick_in  in  1  one-cycle system tick pulse
yield_in  in  1  one-cycle software yield request
highpriority_in  in  PRI_W  from lists_manager highpriority_out
ptr_hpritask_in  in  ID_W  from lists_manager ptr_hpritask_out
tcb_read_in  in  TCB_W  from lists_manager tcb_read_out, valid 1 cycle after addr_read_out
addr_read_out  out  ID_W  to lists_manager addr_read_in
tickval_out  out  TICK_W  to lists_manager tickval_in
rotate_cmd_out  out  1  one-cycle pulse, to lists_manager insert_cmd (current task to list tail)
rotate_id_out  out  ID_W  id for rotate
rotate_pri_out  out  PRI_W  priority for rotate
cs_req_out  out  1  context-switch request to CPU
cs_ack_in  in  1  CPU acknowledge
cs_first_out  out  1  no previous task (first dispatch)
cs_prev_tcb_out  out  TCB_W  outgoing task TCB
cs_next_tcb_out  out  TCB_W  incoming task TCB
cur_valid_out  out  1  a task is running
cur_id_out  out  ID_W  running task id
cur_pri_out  out  PRI_W  running task priority

Behaviour:
- Reset: all outputs 0; FSM IDLE; slice counter = SLICE_TICKS; pending-yield flag 0.
- tickval_out += 1 on each tick_in, in every state, wraps at 2^TICK_W-1 -> 0.
- Slice counter decrements on tick_in only in IDLE with cur_valid_out=1; saturates at 0.
- FSM states: IDLE, ROTATE, SETTLE, FETCH, CAPTURE, REQ.
- IDLE: if !sched_en stay. Else take the first true condition, in priority order:
  (a) !cur_valid_out -> FETCH.
  (b) highpriority_in > cur_pri_out -> FETCH (preempt).
  (c) (slice==0 or yield pending) and highpriority_in == cur_pri_out -> ROTATE.
  (d) otherwise stay; clear yield pending; reload slice if it is 0.
- yield_in in any state sets yield pending; cleared on leaving ROTATE or in (d).
- ROTATE: 1 cycle; rotate_cmd_out=1 with rotate_id_out=cur_id_out, rotate_pri_out=cur_pri_out -> SETTLE.
- SETTLE: 2 cycles for list manager update. Then:
  - if ptr_hpritask_in == cur_id_out (sole task at that priority): reload slice -> IDLE;
  - else -> FETCH.
- FETCH: latch candidate id=ptr_hpritask_in, pri=highpriority_in; addr_read_out=candidate id -> CAPTURE.
- CAPTURE: latch tcb_read_in as next TCB -> REQ.
- REQ: cs_req_out=1; cs_next_tcb_out, cs_prev_tcb_out (current TCB, 0 if none) and cs_first_out=!cur_valid_out held stable. On cs_ack_in=1 (same cycle counts):
  - cs_req_out drops next cycle;
  - cur_* take the candidate values;
  - current TCB updated;
  - slice reloaded;
  - -> IDLE.
- Latency: idle-to-request is 3 cycles for preempt, 6 for rotate.
- cs_ack_in outside REQ is ignored.
- Candidate is frozen from FETCH to the end of REQ; list changes in that window are re-evaluated in the next IDLE cycle.
- sched_en falling mid-sequence does not abort; the sequence completes.
- Reset in any state, including mid-handshake: immediate return to reset values; cs_req_out low the next cycle.

Decomposition:
- Package rtos_pkg:
  - ID_W, PRI_W, TCB_W, TICK_W defaults;
  - FSM state encoding;
  - null TCB constant (0).
- Sub-module rtos_tick_slice: tick counter plus slice counter, with reload/enable/zero flag.

Test Plan:
- Reset, sched_en=1, highpriority_in=0xB, ptr_hpritask_in=0, tcb_read_in=0xFAFFFFFF (one cycle after addr=0):
  - cs_req_out rises with cs_first_out=1, next=0xFAFFFFFF, prev=0;
  - ack -> cur_id=0, cur_pri=0xB.
- Running id 0 pri 0xB; highpriority_in->0xC, ptr=2, tcb=0xCCCCCCCC:
  - request 3 cycles later, prev=0xFAFFFFFF, next=0xCCCCCCCC;
  - ack -> cur_id=2.
- Running pri 0xB, SLICE_TICKS=10, after rotate ptr becomes 1:
  - 10 tick pulses -> single rotate_cmd_out pulse with id 0, pri 0xB;
  - then request for id 1.
- Running sole task at pri 0xB, yield_in pulse, ptr stays at current id:
  - rotate pulse, no cs_req_out;
  - slice reloaded to 10.
- areset held 1 cycle while cs_req_out=1:
  - cs_req_out=0, cur_valid_out=0, tickval_out=0 next cycle;
  - a late cs_ack_in is ignored.
- 300 tick pulses in mixed states:
  - tickval_out=300 (0x12C);
  - tick_in during REQ still counts.
